// File: rtl/uart_io_mem_pkg.sv
// Shared types and constants for the memory-to-UART stream reader.
package uart_io_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [3:0]  BE_ALL         = 4'hF;

endpackage

// File: rtl/uart_io_sync_fifo.sv
// Single-clock word FIFO; head entry is always presented from storage registers.
module uart_io_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[AW'(i)] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/uart_io_mem_stream_reader.sv
// Avalon-MM read master: fetches a block of words and streams them out as little-endian bytes.
module uart_io_mem_stream_reader
    import uart_io_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned MAX_PENDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_words,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [7:0]        st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned WA_W = ADDR_W - 2;
    localparam int unsigned PW   = $clog2(MAX_PENDING + 1);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);

    state_e          r_state;
    logic            r_read;
    logic [WA_W-1:0] r_waddr;
    logic [15:0]     r_remaining;
    logic [15:0]     r_words_out;
    logic [PW-1:0]   r_pending;
    logic [1:0]      r_byte_idx;
    logic            r_done;

    logic            w_cmd_fire;
    logic            w_accept;
    logic            w_rdv;
    logic            w_hs;
    logic            w_word_pop;
    logic            w_last_hs;
    logic [31:0]     w_fifo_data;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_fifo_count;
    logic [15:0]     w_rem_next;
    logic [PW-1:0]   w_pend_next;
    logic [CW-1:0]   w_cnt_next;
    logic            w_issue_next;
    logic            w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^cmd_addr[1:0];

    assign cmd_ready  = (r_state == ST_IDLE) && !reset;
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_accept   = r_read && !avm_waitrequest;
    // Returns arriving while idle are stale reads from an abandoned command.
    assign w_rdv      = avm_readdatavalid && (r_state != ST_IDLE);

    uart_io_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rdv),
        .i_wdata (avm_readdata),
        .i_pop   (w_word_pop),
        .o_rdata (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign st_valid   = !w_fifo_empty;
    assign st_data    = w_fifo_data[{r_byte_idx, 3'b000} +: 8];
    assign st_last    = st_valid && (r_byte_idx == 2'(BYTES_PER_WORD - 1)) && (r_words_out == 16'd1);
    assign w_hs       = st_valid && st_ready;
    assign w_word_pop = w_hs && (r_byte_idx == 2'(BYTES_PER_WORD - 1));
    assign w_last_hs  = w_hs && st_last;

    // Credit check uses next-cycle counts so reads can go out back-to-back.
    assign w_rem_next   = r_remaining - {15'd0, w_accept};
    assign w_pend_next  = r_pending + PW'(w_accept) - PW'(w_rdv);
    assign w_cnt_next   = w_fifo_count + CW'(w_rdv) - CW'(w_word_pop);
    assign w_issue_next = (r_state == ST_ISSUE) && (w_rem_next != '0)
                          && (32'(w_pend_next) < MAX_PENDING)
                          && ((32'(w_pend_next) + 32'(w_cnt_next)) < FIFO_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_read      <= 1'b0;
            r_waddr     <= '0;
            r_remaining <= '0;
            r_words_out <= '0;
            r_pending   <= '0;
            r_byte_idx  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_pending   <= w_pend_next;
            r_remaining <= w_rem_next;
            if (w_accept) begin
                r_waddr <= r_waddr + 1'b1;
            end
            if (w_hs) begin
                r_byte_idx <= r_byte_idx + 1'b1;
            end
            if (w_word_pop) begin
                r_words_out <= r_words_out - 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_read <= 1'b0;
                    if (w_cmd_fire) begin
                        r_waddr     <= cmd_addr[ADDR_W-1:2];
                        r_remaining <= cmd_words;
                        r_words_out <= cmd_words;
                        if (cmd_words != '0) begin
                            r_state <= ST_ISSUE;
                            r_read  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_read <= (r_read && avm_waitrequest) || w_issue_next;
                    if (w_accept && (r_remaining == 16'd1)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_read <= 1'b0;
                    if (w_last_hs) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_read  <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address    = {r_waddr, 2'b00};
    assign avm_read       = r_read;
    assign avm_byteenable = BE_ALL;
    assign busy           = (r_state != ST_IDLE);
    assign done           = r_done;

endmodule

// File: tb/tb_uart_io_mem_stream_reader.sv
// Bench for uart_io_mem_stream_reader: memory slave model with address and byte scoreboards.
module tb_uart_io_mem_stream_reader;

    localparam int unsigned ADDR_W = 18;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_words;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest   = 1'b0;
    logic [31:0]       avm_readdata      = '0;
    logic              avm_readdatavalid = 1'b0;
    logic [7:0]        st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_last;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    uart_io_mem_stream_reader #(
        .ADDR_W      (ADDR_W),
        .FIFO_DEPTH  (8),
        .MAX_PENDING (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_addr          (cmd_addr),
        .cmd_words         (cmd_words),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .st_data           (st_data),
        .st_valid          (st_valid),
        .st_ready          (st_ready),
        .st_last           (st_last),
        .busy              (busy),
        .done              (done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0]       mem [0:65535];
    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [8:0]        exp_byte_q [$];
    int                resp_due_q [$];
    logic [15:0]       resp_wa_q  [$];

    int cyc         = 0;
    bit rand_mode   = 1'b0;
    int lat_fixed   = 1;
    int acc_total   = 0;
    int outstanding = 0;
    int pop_total   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory slave: in-order returns, configurable latency and stalls.
    bit                prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    always @(negedge clk) begin
        bit acc;
        int lat;
        if (resp_due_q.size() != 0 && resp_due_q[0] <= cyc + 1) begin
            void'(resp_due_q.pop_front());
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem[resp_wa_q.pop_front()];
            outstanding--;
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = $urandom;
        end
        avm_waitrequest = rand_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (prev_stall) begin
            check("stall_read_held", avm_read, 1);
            check("stall_addr_held", avm_address, prev_addr);
        end
        acc = avm_read && !avm_waitrequest && !reset;
        if (acc) begin
            if (exp_addr_q.size() == 0) check("addr_extra", exp_addr_q.size(), 1);
            else check("avm_address", avm_address, exp_addr_q.pop_front());
            lat = rand_mode ? int'($urandom_range(1, 5)) : lat_fixed;
            resp_due_q.push_back(cyc + 1 + lat);
            resp_wa_q.push_back(avm_address[ADDR_W-1:2]);
            acc_total++;
            outstanding++;
            check("pending_le_4", (outstanding <= 4), 1);
        end
        prev_stall = avm_read && avm_waitrequest && !reset;
        prev_addr  = avm_address;
    end

    // Byte monitor and done-pulse checker.
    bit prev_last = 1'b0;
    bit zw_allow  = 1'b0;
    int mon_bidx  = 0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (!zw_allow) check("done_pulse", done, prev_last);
        if (prev_last) begin
            check("busy_after_last", busy, 0);
            check("cmd_ready_after_last", cmd_ready, 1);
        end
        prev_last = 1'b0;
        if (reset) begin
            mon_bidx = 0;
        end else if (st_valid && st_ready) begin
            if (exp_byte_q.size() == 0) begin
                check("byte_extra", exp_byte_q.size(), 1);
            end else begin
                e = exp_byte_q.pop_front();
                check("st_data", st_data, e[7:0]);
                check("st_last", st_last, e[8]);
            end
            prev_last = st_last;
            if (mon_bidx == 3) begin
                mon_bidx = 0;
                pop_total++;
            end else begin
                mon_bidx++;
            end
        end
    end

    task automatic send_cmd(input logic [ADDR_W-1:0] addr, input logic [15:0] words);
        logic [15:0] wa;
        logic [31:0] d;
        wa = addr[ADDR_W-1:2];
        for (int unsigned i = 0; i < words; i++) begin
            exp_addr_q.push_back({wa, 2'b00});
            d = mem[wa];
            for (int unsigned b = 0; b < 4; b++)
                exp_byte_q.push_back({((i == words - 1) && (b == 3)), d[8*b +: 8]});
            wa++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_words = words;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
    endtask

    initial begin
        int a0;
        int p0;
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = {16'(i) ^ 16'hC35A, ~16'(i)};
        mem[16'h0040] = 32'h44332211;
        mem[16'h0041] = 32'h88776655;
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_words = '0; st_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_avm_read", avm_read, 0);
        check("rst_avm_address", avm_address, 0);
        check("rst_byteenable", avm_byteenable, 4'hF);
        check("rst_st_valid", st_valid, 0);
        check("rst_st_data", st_data, 0);
        check("rst_st_last", st_last, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Two words at 0x100, no stalls
        a0 = acc_total;
        send_cmd(18'h00100, 16'd2);
        @(negedge clk);
        check("t1_read_cycle1", avm_read, 1);
        check("t1_addr_cycle1", avm_address, 18'h00100);
        check("t1_busy", busy, 1);
        wait_done("t1_done", 50);
        check("t1_read_count", acc_total - a0, 2);
        check("t1_bytes_left", exp_byte_q.size(), 0);

        // Zero-word command
        @(posedge clk); #1 zw_allow = 1'b1;
        a0 = acc_total;
        send_cmd(18'h00200, 16'd0);
        @(negedge clk);
        check("zw_done_cycle1", done, 1);
        check("zw_cmd_ready", cmd_ready, 1);
        check("zw_no_read", avm_read, 0);
        @(negedge clk);
        check("zw_done_single", done, 0);
        check("zw_no_read2", avm_read, 0);
        check("zw_read_count", acc_total - a0, 0);
        @(posedge clk); #1 zw_allow = 1'b0;

        // Address wrap at top of space
        send_cmd(18'h3FFFE, 16'd2);
        wait_done("wrap_done", 50);
        check("wrap_addr_left", exp_addr_q.size(), 0);

        // Random stalls and latency over 64 words
        @(posedge clk); #1 rand_mode = 1'b1;
        send_cmd(18'h08000, 16'd64);
        wait_done("rand_done", 3000);
        check("rand_bytes_left", exp_byte_q.size(), 0);
        @(posedge clk); #1 rand_mode = 1'b0;

        // Downstream stall: credit must cap in-flight words at the FIFO depth
        lat_fixed = 2;
        @(posedge clk); #1 st_ready = 1'b0;
        a0 = acc_total;
        p0 = pop_total;
        send_cmd(18'h01000, 16'd32);
        repeat (50) @(negedge clk);
        check("stall_inflight", (acc_total - a0) - (pop_total - p0), 8);
        check("stall_no_pop", pop_total - p0, 0);
        check("stall_read_off", avm_read, 0);
        @(posedge clk); #1 st_ready = 1'b1;
        wait_done("stall_done", 1000);
        check("stall_bytes_left", exp_byte_q.size(), 0);

        // Reset mid-command with reads outstanding
        lat_fixed = 5;
        send_cmd(18'h00400, 16'd16);
        n = 0;
        while (outstanding < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_pending_seen", (outstanding >= 2), 1);
        @(posedge clk); #1 reset = 1'b1;
        exp_addr_q.delete();
        exp_byte_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_read", avm_read, 0);
        check("mid_rst_st_valid", st_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_addr", avm_address, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("stale_st_valid", st_valid, 0);
            check("stale_busy", busy, 0);
        end
        check("stale_drained", outstanding, 0);
        lat_fixed = 1;
        send_cmd(18'h00100, 16'd2);
        wait_done("post_rst_done", 50);
        check("post_rst_bytes_left", exp_byte_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_io_mem_stream_reader.md
# uart_io_mem_stream_reader

Avalon-MM read master that fetches a block of 32-bit words from the on-chip memory and emits them as a little-endian byte stream toward the UART transmit path. It is the initiator counterpart of the on-chip memory slave and sits between the system interconnect and the TX byte FIFO. It supports pipelined reads with `waitrequest` and `readdatavalid`, and uses credit-based flow control so that returning data is never dropped.

## Interface
Parameters:
- `ADDR_W`, 18: byte-address width of the master port; the word address is `ADDR_W-2` bits.
- `FIFO_DEPTH`, 8: word buffer depth; must be a power of two and at least 2.
- `MAX_PENDING`, 4: maximum number of issued reads still awaiting `readdatavalid`.

Ports:
- `clk`  in  1  Single clock.
- `reset`  in  1  Synchronous, active-high.
- `cmd_valid`  in  1  Command request.
- `cmd_ready`  out  1  High only in IDLE and not in reset.
- `cmd_addr`  in  ADDR_W  Start byte address; bits [1:0] are ignored (forced to 0).
- `cmd_words`  in  16  Number of 32-bit words to read.
- `avm_address`  out  ADDR_W  Byte address of the read; always word-aligned.
- `avm_read`  out  1  Read request.
- `avm_byteenable`  out  4  Constant 4'hF.
- `avm_waitrequest`  in  1  Interconnect stall.
- `avm_readdata`  in  32  Read data.
- `avm_readdatavalid`  in  1  Read data valid.
- `st_data`  out  8  Byte output.
- `st_valid`  out  1  Byte output valid.
- `st_ready`  in  1  Downstream ready.
- `st_last`  out  1  Marks the final byte of the command.
- `busy`  out  1  High whenever the block is not in IDLE.
- `done`  out  1  One-cycle completion pulse.

## Operation
- **States:** IDLE, ISSUE, DRAIN.
  - IDLE → ISSUE when `cmd_valid & cmd_ready` and `cmd_words != 0`.
  - IDLE stays in IDLE when a command is accepted with `cmd_words == 0`; `done` pulses on the next cycle and no read is issued.
  - ISSUE → DRAIN when the last read is accepted.
  - DRAIN → IDLE on the `st_valid & st_ready` handshake of the byte with `st_last = 1`.
- **Read acceptance:** a read is accepted when `avm_read & ~avm_waitrequest`. While `avm_waitrequest` is high, `avm_read` and `avm_address` are held stable.
- **Address:** increments by 4 per accepted read and wraps modulo 2^ADDR_W without error.
- **Issue condition** for a new read, all required:
  - state is ISSUE;
  - `remaining > 0`;
  - `pending < MAX_PENDING`;
  - `pending + fifo_count < FIFO_DEPTH`.
- **Overflow guarantee:** the issue condition ensures the FIFO never overflows.
- **Pending counter:** +1 on acceptance and −1 on `readdatavalid`. When both occur in the same cycle, the counter is unchanged.
- **FIFO push:** every `avm_readdatavalid` pushes `avm_readdata` into the FIFO. `readdatavalid` while in IDLE is ignored; this covers stale returns after reset.
- **Unpacker:** pops one word and emits bytes [7:0], [15:8], [23:16], [31:24] in that order. It holds `st_data` and `st_valid` stable until `st_ready`, then advances the byte index.
- **st_last:** asserted together with byte 3 of word `cmd_words-1`.
- **Reset values:** all outputs 0 (`avm_byteenable` = 4'hF); state IDLE; counters, FIFO and byte index cleared.
- **Reset mid-operation:** the command is abandoned and no `done` is generated.

## Timing
- Command accepted in cycle 0 → `avm_read` high with `avm_address = cmd_addr & ~3` in cycle 1.
- Reads issue back-to-back, one per cycle, while credit is available and `waitrequest` is low.
- `readdatavalid` in cycle N → FIFO not empty in cycle N+1 → earliest `st_valid` in cycle N+1.
- With `st_ready` held high, throughput is 1 byte per cycle with no bubbles between words.
- `done` asserts in the cycle after the final byte handshake. `cmd_ready` rises in that same cycle.
- `busy` falls in the same cycle that `done` asserts.

## Structure
- Package `uart_io_mem_pkg` holds:
  - the state enum (IDLE, ISSUE, DRAIN);
  - `BYTES_PER_WORD = 4`;
  - `BE_ALL = 4'hF`.
- Sub-module `uart_io_sync_fifo`: single-clock, parameterised width and depth, registered output, `count` output, synchronous active-high reset.
- The top level contains the FSM, the address/remaining/pending counters and the byte unpacker.

## Test plan
- Command `addr = 0x100`, `words = 2`; memory holds 0x44332211, 0x88776655; `st_ready` = 1; no waitrequest → bytes 11 22 33 44 55 66 77 88, `st_last` on 88, `done` 1 cycle later, exactly 2 reads.
- `words = 0` → `done` pulse in cycle 1, `avm_read` never asserted, `cmd_ready` stays high.
- `waitrequest` randomly high, and `readdatavalid` latency randomly 1–5 cycles → address held stable during stalls, `pending` never exceeds 4, byte order intact over 64 words.
- `st_ready` = 0 for 50 cycles during a 32-word command → issue stops once `pending + fifo_count = 8`, no data lost, all 128 bytes delivered in order.
- `cmd_addr = 0x3FFFE` (ADDR_W = 18), `words = 2` → read addresses 0x3FFFC then 0x00000.
- `reset` asserted mid-command with 2 reads pending → outputs zero, late `readdatavalid` ignored, no `done`, and a following command completes correctly.
